// File: rtl/four_bit_sort_ctrl_if.sv
// Handshake, read-port and comparator-link signals of the four-bit sort controller.
// The slave modport is the controller's view; master is the driving environment.
interface four_bit_sort_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          load_valid;
  logic [3:0]    load_data;
  logic          load_ready;
  logic          start;
  logic          clear;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_data;
  logic [3:0]    cmp_a;
  logic [3:0]    cmp_b;
  logic          cmp_eq;
  logic          cmp_lt;
  logic          cmp_gt;
  logic [7:0]    swap_count;
  logic          cmp_err;

  modport master (
    output load_valid, load_data, start, clear, rd_addr, cmp_eq, cmp_lt, cmp_gt,
    input  load_ready, busy, done, rd_data, cmp_a, cmp_b, swap_count, cmp_err
  );

  modport slave (
    input  load_valid, load_data, start, clear, rd_addr, cmp_eq, cmp_lt, cmp_gt,
    output load_ready, busy, done, rd_data, cmp_a, cmp_b, swap_count, cmp_err
  );
endinterface

// File: rtl/four_bit_sort_ctrl.sv
// Stable in-place bubble sort of up to DEPTH 4-bit entries, one pair per COMPARE
// cycle, using an external comparator; early exit on a pass without swaps.
module four_bit_sort_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  four_bit_sort_ctrl_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] pass_q, pass_d;
  logic          pass_swapped_q, pass_swapped_d;
  logic [7:0]    swap_count_q, swap_count_d;
  logic          cmp_err_q, cmp_err_d;
  logic [3:0]    rd_data_q, rd_data_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];

  logic [AW-1:0] i_nxt;
  logic [AW:0]   last_i;
  logic          one_hot;
  logic          load_ready;
  logic          advance;
  logic          swapped_eff;

  assign i_nxt   = i_q + AW'(1);
  // Index of the last pair in the current pass; pass never exceeds count-2.
  assign last_i  = count_q - (AW+1)'(2) - {1'b0, pass_q};
  assign one_hot = ({bus.cmp_eq, bus.cmp_lt, bus.cmp_gt} == 3'b100) ||
                   ({bus.cmp_eq, bus.cmp_lt, bus.cmp_gt} == 3'b010) ||
                   ({bus.cmp_eq, bus.cmp_lt, bus.cmp_gt} == 3'b001);

  assign load_ready     = (state_q == IDLE) && (count_q < (AW+1)'(DEPTH)) &&
                          !bus.start && !bus.clear;
  assign bus.load_ready = load_ready;
  assign bus.busy       = (state_q == COMPARE) || (state_q == SWAP);
  assign bus.done       = (state_q == DONE);
  assign bus.cmp_a      = (state_q == COMPARE) ? mem_q[i_q]   : 4'h0;
  assign bus.cmp_b      = (state_q == COMPARE) ? mem_q[i_nxt] : 4'h0;
  assign bus.rd_data    = rd_data_q;
  assign bus.swap_count = swap_count_q;
  assign bus.cmp_err    = cmp_err_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d        = state_q;
    count_d        = count_q;
    i_d            = i_q;
    pass_d         = pass_q;
    pass_swapped_d = pass_swapped_q;
    swap_count_d   = swap_count_q;
    cmp_err_d      = cmp_err_q;
    mem_d          = mem_q;
    rd_data_d      = mem_q[bus.rd_addr];
    advance        = 1'b0;
    swapped_eff    = pass_swapped_q;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          count_d      = '0;
          swap_count_d = '0;
          cmp_err_d    = 1'b0;
        end else if (bus.start) begin
          state_d        = (count_q < (AW+1)'(2)) ? DONE : COMPARE;
          pass_d         = '0;
          i_d            = '0;
          swap_count_d   = '0;
          pass_swapped_d = 1'b0;
        end else if (bus.load_valid && load_ready) begin
          mem_d[count_q[AW-1:0]] = bus.load_data;
          count_d                = count_q + (AW+1)'(1);
        end
      end
      COMPARE: begin
        if (!one_hot) cmp_err_d = 1'b1;
        // Only a strict, well-formed "greater" swaps, which keeps equal keys in order.
        if (one_hot && bus.cmp_gt) state_d = SWAP;
        else                       advance = 1'b1;
      end
      SWAP: begin
        mem_d[i_q]   = mem_q[i_nxt];
        mem_d[i_nxt] = mem_q[i_q];
        if (swap_count_q != 8'hFF) swap_count_d = swap_count_q + 8'd1;
        swapped_eff  = 1'b1;
        advance      = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if ({1'b0, i_q} == last_i) begin
        if (!swapped_eff || ({1'b0, pass_q} == count_q - (AW+1)'(2))) begin
          state_d = DONE;
        end else begin
          pass_d         = pass_q + AW'(1);
          i_d            = '0;
          pass_swapped_d = 1'b0;
          state_d        = COMPARE;
        end
      end else begin
        i_d            = i_nxt;
        pass_swapped_d = swapped_eff;
        state_d        = COMPARE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      i_q            <= '0;
      pass_q         <= '0;
      pass_swapped_q <= 1'b0;
      swap_count_q   <= '0;
      cmp_err_q      <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      i_q            <= i_d;
      pass_q         <= pass_d;
      pass_swapped_q <= pass_swapped_d;
      swap_count_q   <= swap_count_d;
      cmp_err_q      <= cmp_err_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // NOTE: the buffer is deliberately not reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_four_bit_sort_ctrl.sv
// Directed bench for four_bit_sort_ctrl with a behavioural comparator that can
// be forced to a non-one-hot result.
module tb_four_bit_sort_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_err = 1'b0;

  four_bit_sort_ctrl_if #(.DEPTH(DEPTH)) bus ();

  four_bit_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.cmp_eq = (bus.cmp_a == bus.cmp_b);
    bus.cmp_lt = (bus.cmp_a <  bus.cmp_b);
    bus.cmp_gt = (bus.cmp_a >  bus.cmp_b);
    if (force_err) begin
      bus.cmp_eq = 1'b0;
      bus.cmp_lt = 1'b1;
      bus.cmp_gt = 1'b1;
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int guard       = 0;
  int eq_seen     = 0;
  logic prev_eq   = 1'b0;

  logic [3:0] t1_in  [8] = '{4'h7, 4'h3, 4'hF, 4'h0, 4'h3, 4'hA, 4'h1, 4'h8};
  logic [3:0] t1_out [8] = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h7, 4'h8, 4'hA, 4'hF};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a, input logic [3:0] exp);
    bus.rd_addr = 3'(a);
    step();
    check(tag, 8'(bus.rd_data), 8'(exp));
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic start_sort();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check({tag, "_done"}, 8'(bus.done), 8'd1);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = 4'h0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.rd_addr    = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_busy",       8'(bus.busy),       8'd0);
    check("rst_done",       8'(bus.done),       8'd0);
    check("rst_load_ready", 8'(bus.load_ready), 8'd1);
    check("rst_swap_count", bus.swap_count,     8'd0);
    check("rst_cmp_err",    8'(bus.cmp_err),    8'd0);
    check("rst_rd_data",    8'(bus.rd_data),    8'd0);

    // Mixed data with duplicate 3s: 14 strict inversions.
    for (int k = 0; k < 8; k++) do_load(t1_in[k]);
    start_sort();
    guard = 0;
    while (bus.done !== 1'b1 && guard < 300) begin
      if (prev_eq)
        check("t1_equal_pair_not_swapped",
              8'(bus.busy && bus.cmp_a == 4'h0 && bus.cmp_b == 4'h0), 8'd0);
      prev_eq = (bus.cmp_a == 4'h3) && (bus.cmp_b == 4'h3);
      if (prev_eq) eq_seen++;
      step();
      guard++;
    end
    check("t1_done",          8'(bus.done),      8'd1);
    check("t1_busy_at_done",  8'(bus.busy),      8'd0);
    check("t1_3s_compared",   8'(eq_seen > 0),   8'd1);
    check("t1_swap_count",    bus.swap_count,    8'd14);
    step();
    check("t1_done_one_cycle", 8'(bus.done), 8'd0);
    check("t1_busy_after",     8'(bus.busy), 8'd0);
    for (int k = 0; k < 8; k++) read_check("t1_rd", k, t1_out[k]);

    // Already sorted: one pass of 7 compares, done at T+8.
    do_clear();
    check("t2_clear_swap_count", bus.swap_count, 8'd0);
    for (int k = 0; k < 8; k++) do_load(4'(k));
    start_sort();
    for (int k = 0; k < 7; k++) begin
      check("t2_busy", 8'(bus.busy), 8'd1);
      check("t2_done_early", 8'(bus.done), 8'd0);
      step();
    end
    check("t2_done_t8",     8'(bus.done),   8'd1);
    check("t2_swap_count",  bus.swap_count, 8'd0);
    step();

    // Reverse order: worst case, 28 swaps.
    do_clear();
    for (int k = 0; k < 8; k++) do_load(4'(15 - k));
    start_sort();
    wait_done("t3");
    check("t3_swap_count", bus.swap_count, 8'd28);
    step();
    for (int k = 0; k < 8; k++) read_check("t3_rd", k, 4'(8 + k));

    // Corrupted comparator result on the first pair of 2,1,3.
    do_clear();
    do_load(4'h2);
    do_load(4'h1);
    do_load(4'h3);
    start_sort();
    check("t4_cmp_a0", 8'(bus.cmp_a), 8'h2);
    check("t4_cmp_b0", 8'(bus.cmp_b), 8'h1);
    force_err = 1'b1;
    step();
    force_err = 1'b0;
    check("t4_cmp_err_set", 8'(bus.cmp_err), 8'd1);
    check("t4_cmp_a1",      8'(bus.cmp_a),   8'h1);
    check("t4_cmp_b1",      8'(bus.cmp_b),   8'h3);
    wait_done("t4");
    check("t4_swap_count", bus.swap_count,    8'd0);
    check("t4_err_hold",   8'(bus.cmp_err),   8'd1);
    step();
    read_check("t4_rd0", 0, 4'h2);
    read_check("t4_rd1", 1, 4'h1);
    // Re-sort the persisted entries; a clear while busy must be ignored.
    start_sort();
    do_clear();
    check("t4_busy_clear_ignored", 8'(bus.busy),    8'd1);
    check("t4_err_busy_clear",     8'(bus.cmp_err), 8'd1);
    wait_done("t4b");
    check("t4b_swap_count", bus.swap_count, 8'd1);
    check("t4b_err_hold",   8'(bus.cmp_err), 8'd1);
    step();
    read_check("t4b_rd0", 0, 4'h1);
    read_check("t4b_rd1", 1, 4'h2);
    read_check("t4b_rd2", 2, 4'h3);
    do_clear();
    check("t4_err_cleared",   8'(bus.cmp_err), 8'd0);
    check("t4_swap_cleared",  bus.swap_count,  8'd0);
    start_sort();
    check("t4_count0_done",   8'(bus.done),    8'd1);
    step();

    // Single entry, load/start collision, and a full buffer.
    do_load(4'h5);
    start_sort();
    check("t5_done_t1", 8'(bus.done), 8'd1);
    check("t5_busy",    8'(bus.busy), 8'd0);
    step();
    check("t5_busy_after", 8'(bus.busy), 8'd0);
    read_check("t5_rd0", 0, 4'h5);
    bus.start      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'h9;
    #1;
    check("t5_ready_with_start", 8'(bus.load_ready), 8'd0);
    step();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    check("t5_start_done", 8'(bus.done), 8'd1);
    step();
    read_check("t5_rd1_no_write", 1, 4'h2);
    for (int k = 0; k < 7; k++) do_load(4'(k));
    bus.load_valid = 1'b1;
    bus.load_data  = 4'hF;
    #1;
    check("t5_full_ready", 8'(bus.load_ready), 8'd0);
    step();
    bus.load_valid = 1'b0;
    read_check("t5_rd7", 7, 4'h6);
    read_check("t5_rd0_kept", 0, 4'h5);

    // Reset in the middle of a SWAP.
    do_clear();
    for (int k = 0; k < 8; k++) do_load(4'(15 - k));
    start_sort();
    step();
    check("t6_in_swap_busy", 8'(bus.busy),  8'd1);
    check("t6_in_swap_cmpa", 8'(bus.cmp_a), 8'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_busy",       8'(bus.busy),       8'd0);
    check("t6_done",       8'(bus.done),       8'd0);
    check("t6_load_ready", 8'(bus.load_ready), 8'd1);
    check("t6_swap_count", bus.swap_count,     8'd0);
    check("t6_cmp_err",    8'(bus.cmp_err),    8'd0);
    check("t6_rd_data",    8'(bus.rd_data),    8'd0);
    start_sort();
    check("t6_count0_done", 8'(bus.done), 8'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/four_bit_sort_ctrl.md
FOUR_BIT_SORT_CTRL -- requirements
Module: four_bit_sort_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of 4-bit entries in the sort buffer; SHALL be a power of two, 2..16; AW = clog2(DEPTH).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  load_data is presented for writing into the buffer.
REQ-005 load_data  input  4  value to append to the buffer.
REQ-006 load_ready  output  1  buffer accepts a load this cycle.
REQ-007 start  input  1  request to sort the loaded entries.
REQ-008 clear  input  1  empty the buffer and clear status.
REQ-009 busy  output  1  sort in progress.
REQ-010 done  output  1  single-cycle pulse when a sort completes.
REQ-011 rd_addr  input  AW  buffer read address.
REQ-012 rd_data  output  4  registered buffer read data.
REQ-013 cmp_a, cmp_b  output  4 each  operands driven to the external four_bit_comparator.
REQ-014 cmp_eq, cmp_lt, cmp_gt  input  1 each  comparator results: a==b, a<b, a>b.
REQ-015 swap_count  output  8  number of swaps performed by the last or current sort.
REQ-016 cmp_err  output  1  sticky flag: comparator result was not one-hot.

Function
REQ-017 States SHALL be IDLE, COMPARE, SWAP and DONE; count (0..DEPTH) SHALL track loaded entries.
REQ-018 load_ready SHALL equal (state==IDLE) && (count<DEPTH) && !start && !clear.
REQ-019 A load SHALL write mem[count] <= load_data and increment count when load_valid && load_ready.
REQ-020 clear SHALL be honoured in IDLE only: count, swap_count and cmp_err go to 0 next cycle; clear has priority over start; clear outside IDLE SHALL be ignored.
REQ-021 start in IDLE (without clear) SHALL leave IDLE: to DONE if count<2, else to COMPARE with pass=0, i=0, swap_count=0 and pass_swapped=0; start outside IDLE SHALL be ignored.
REQ-022 In COMPARE, cmp_a SHALL be mem[i] and cmp_b SHALL be mem[i+1] combinationally; in all other states both SHALL be 0.
REQ-023 A COMPARE cycle with cmp_gt=1 and a one-hot result SHALL go to SWAP; otherwise the pair SHALL be left unswapped. Equal values are never swapped, so the sort is stable.
REQ-024 SWAP SHALL exchange mem[i] and mem[i+1] in one cycle, increment swap_count and set pass_swapped.
REQ-025 After each pair, i SHALL advance. When i reaches count-2-pass, the pass ends. If pass_swapped=0, or pass equals count-2, the next state is DONE. Otherwise pass increments, i=0, pass_swapped=0, and the next state is COMPARE.
REQ-026 busy SHALL be 1 exactly in COMPARE and SWAP; done SHALL be 1 exactly in DONE, which lasts one cycle and then returns to IDLE.
REQ-027 count and the buffer contents SHALL persist after DONE, so a second start re-sorts them.
REQ-028 rd_data SHALL be mem[rd_addr] registered, valid one cycle after rd_addr, in any state. A read during a sort returns in-flight contents. rd_addr >= count returns the stale contents of that entry.
REQ-029 cmp_err SHALL set when a COMPARE cycle sees cmp_eq+cmp_lt+cmp_gt != 1, and hold until rst or clear.
REQ-030 swap_count SHALL saturate at 255; the maximum reachable value is DEPTH*(DEPTH-1)/2.

Reset
REQ-031 rst SHALL, in any state including mid-sort, force state=IDLE, count=0, swap_count=0, cmp_err=0, busy=0, done=0 and rd_data=0 on the next edge.
REQ-032 After reset, load_ready=1. Buffer contents are not reset and SHALL be treated as don't-care.
REQ-033 rst SHALL have priority over clear, start and load.

Verification
REQ-034 DEPTH=8. Load 7,3,F,0,3,A,1,8, then start -> done pulses once, busy low afterwards, and reading addresses 0..7 returns 0,1,3,3,7,8,A,F. Check that the two 3s keep their load order by tracing cmp operands.
REQ-035 Load 0..7, start at cycle T -> COMPARE at T+1..T+7, done=1 at T+8, swap_count=0.
REQ-036 Load F,E,D,C,B,A,9,8, start -> result 8..F, swap_count=28.
REQ-037 Load one value 5, start at T -> done=1 at T+1, busy never 1, rd 0 = 5. Load at count=8 -> load_ready=0, no write. Start and load_valid in the same cycle -> load not accepted.
REQ-038 Assert rst for one cycle mid-sort during SWAP -> next cycle busy=0, done=0, load_ready=1, swap_count=0, cmp_err=0. A later start with count=0 -> done at T+1.
REQ-039 Force cmp_lt=cmp_gt=1 on one COMPARE -> cmp_err=1, that pair is not swapped, the sort still completes. cmp_err stays 1 until clear in IDLE, then reads 0 with count=0.
